// File: rtl/im_loader.sv
// im_loader: boot-time instruction loader for the sisc core.
// Assembles a big-endian byte stream into 32-bit words, writes them to
// consecutive instruction-memory addresses starting at BASE_ADDR, and holds
// the core in reset (CORE_RST_F low) until the whole program is written.
//   CLK/RST            clock, async active-high reset
//   START/WORD_COUNT   load request and word count (sampled in IDLE/DONE/ERR)
//   BYTE_IN/VALID/READY byte stream handshake
//   IM_WE/ADDR/WDATA   instruction-memory write port
//   CORE_RST_F         active-low core reset
//   DONE/ERR           load complete / aborted on timeout
module im_loader #(
  parameter int unsigned          ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = 16'h0000,
  parameter int unsigned          TIMEOUT   = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] WORD_COUNT,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [31:0]       IM_WDATA,
  output logic              CORE_RST_F,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              core_rst_f_q, core_rst_f_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              byte_ready_q, byte_ready_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] words_left_q, words_left_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [23:0]       asm_q, asm_d;

  logic accept;

  assign accept = BYTE_VALID && byte_ready_q;

  always_comb begin
    state_d      = state_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    core_rst_f_d = core_rst_f_q;
    done_d       = done_q;
    err_d        = err_q;
    byte_idx_d   = byte_idx_q;
    words_left_d = words_left_q;
    tmo_d        = tmo_q;
    asm_d        = asm_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          err_d = 1'b0;
          if (WORD_COUNT != '0) begin
            state_d      = S_RECV;
            words_left_d = WORD_COUNT;
            im_addr_d    = BASE_ADDR;
            byte_idx_d   = '0;
            tmo_d        = '0;
            done_d       = 1'b0;
            core_rst_f_d = 1'b0;
          end else begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_rst_f_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          tmo_d      = '0;
          byte_idx_d = byte_idx_q + 2'd1;
          // Earlier bytes shift left, so the first byte ends up as the MSB.
          asm_d      = {asm_q[15:0], BYTE_IN};
          if (byte_idx_q == 2'd3) begin
            im_wdata_d = {asm_q, BYTE_IN};
            im_we_d    = 1'b1;
            state_d    = S_WRITE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_ERR;
          err_d        = 1'b1;
          core_rst_f_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: begin
        im_addr_d    = im_addr_q + 1'b1;
        words_left_d = words_left_q - 1'b1;
        if (words_left_q == ADDR_W'(1)) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          core_rst_f_d = 1'b1;
        end else begin
          state_d    = S_RECV;
          byte_idx_d = '0;
          tmo_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_RECV);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      im_we_q      <= 1'b0;
      im_addr_q    <= BASE_ADDR;
      im_wdata_q   <= '0;
      core_rst_f_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      byte_idx_q   <= '0;
      words_left_q <= '0;
      tmo_q        <= '0;
      asm_q        <= '0;
    end else begin
      state_q      <= state_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_rst_f_q <= core_rst_f_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      byte_idx_q   <= byte_idx_d;
      words_left_q <= words_left_d;
      tmo_q        <= tmo_d;
      asm_q        <= asm_d;
    end
  end

  assign BYTE_READY = byte_ready_q;
  assign IM_WE      = im_we_q;
  assign IM_ADDR    = im_addr_q;
  assign IM_WDATA   = im_wdata_q;
  assign CORE_RST_F = core_rst_f_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed bench for im_loader (TIMEOUT = 16).
module tb_im_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] WORD_COUNT = '0;
  logic [7:0]  BYTE_IN = '0;
  logic        BYTE_VALID = 1'b0;
  logic        BYTE_READY;
  logic        IM_WE;
  logic [15:0] IM_ADDR;
  logic [31:0] IM_WDATA;
  logic        CORE_RST_F;
  logic        DONE;
  logic        ERR;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];

  im_loader #(
    .ADDR_W   (16),
    .BASE_ADDR(16'h0000),
    .TIMEOUT  (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .WORD_COUNT(WORD_COUNT),
    .BYTE_IN   (BYTE_IN),
    .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY),
    .IM_WE     (IM_WE),
    .IM_ADDR   (IM_ADDR),
    .IM_WDATA  (IM_WDATA),
    .CORE_RST_F(CORE_RST_F),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Write log, sampled mid-cycle.
  always @(negedge CLK) begin
    if (IM_WE === 1'b1) begin
      wr_addr.push_back(IM_ADDR);
      wr_data.push_back(IM_WDATA);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents a byte and returns 1ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    logic acc;
    acc = 1'b0;
    BYTE_VALID = 1'b1;
    BYTE_IN    = b;
    for (int i = 0; i < 20; i++) begin
      rdy = BYTE_READY;
      step();
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check("byte_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_we"},    32'(IM_WE),      32'd0);
    check({pfx, "_addr"},  32'(IM_ADDR),    32'h0000);
    check({pfx, "_wdata"}, IM_WDATA,        32'h0);
    check({pfx, "_crst"},  32'(CORE_RST_F), 32'd0);
    check({pfx, "_done"},  32'(DONE),       32'd0);
    check({pfx, "_err"},   32'(ERR),        32'd0);
    check({pfx, "_ready"}, 32'(BYTE_READY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] toggle_bytes [4];
    int unsigned idx;
    logic vld, rdy;

    toggle_bytes[0] = 8'hDE;
    toggle_bytes[1] = 8'hAD;
    toggle_bytes[2] = 8'hBE;
    toggle_bytes[3] = 8'hEF;

    // Reset state
    #12;
    check_reset_state("rst");
    @(negedge CLK);
    RST = 1'b0;
    step();

    // Two words, back-to-back bytes
    START = 1'b1; WORD_COUNT = 16'd2;
    step();
    START = 1'b0;
    check("t1_ready", 32'(BYTE_READY), 32'd1);
    check("t1_crst",  32'(CORE_RST_F), 32'd0);
    send_byte(8'h88); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
    BYTE_VALID = 1'b0;
    check("t1_w0_we",    32'(IM_WE),      32'd1);
    check("t1_w0_addr",  32'(IM_ADDR),    32'h0000);
    check("t1_w0_data",  IM_WDATA,        32'h88100001);
    check("t1_w0_ready", 32'(BYTE_READY), 32'd0);
    step();
    check("t1_w0_we_off", 32'(IM_WE),      32'd0);
    check("t1_ready_back", 32'(BYTE_READY), 32'd1);
    check("t1_addr_inc",  32'(IM_ADDR),    32'h0001);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    BYTE_VALID = 1'b0;
    check("t1_w1_we",   32'(IM_WE),   32'd1);
    check("t1_w1_addr", 32'(IM_ADDR), 32'h0001);
    check("t1_w1_data", IM_WDATA,     32'h12345678);
    check("t1_w1_done_early", 32'(DONE), 32'd0);
    step();
    check("t1_done",  32'(DONE),       32'd1);
    check("t1_crst1", 32'(CORE_RST_F), 32'd1);
    check("t1_we0",   32'(IM_WE),      32'd0);
    check("t1_ready0", 32'(BYTE_READY), 32'd0);
    check("t1_nwr",   32'(wr_data.size()), 32'd2);
    check("t1_log0a", 32'(wr_addr[0]), 32'h0000);
    check("t1_log0d", wr_data[0],      32'h88100001);
    check("t1_log1a", 32'(wr_addr[1]), 32'h0001);
    check("t1_log1d", wr_data[1],      32'h12345678);

    // One word, BYTE_VALID toggling; junk on BYTE_IN while invalid
    START = 1'b1; WORD_COUNT = 16'd1;
    step();
    START = 1'b0;
    check("t2_restart_crst", 32'(CORE_RST_F), 32'd0);
    check("t2_restart_done", 32'(DONE),       32'd0);
    idx = 0;
    vld = 1'b0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      BYTE_VALID = vld;
      BYTE_IN    = vld ? toggle_bytes[idx] : 8'h55;
      rdy        = BYTE_READY;
      step();
      if (vld && rdy) idx++;
      vld = ~vld;
    end
    BYTE_VALID = 1'b0;
    check("t2_all_bytes", idx, 32'd4);
    check("t2_we",   32'(IM_WE),   32'd1);
    check("t2_addr", 32'(IM_ADDR), 32'h0000);
    check("t2_data", IM_WDATA,     32'hDEADBEEF);
    step();
    check("t2_done", 32'(DONE),       32'd1);
    check("t2_crst", 32'(CORE_RST_F), 32'd1);
    check("t2_nwr",  32'(wr_data.size()), 32'd3);
    check("t2_logd", wr_data[2], 32'hDEADBEEF);

    // Reload from DONE, then timeout after three bytes
    START = 1'b1; WORD_COUNT = 16'd1;
    step();
    START = 1'b0;
    check("t3_crst",  32'(CORE_RST_F), 32'd0);
    check("t3_addr",  32'(IM_ADDR),    32'h0000);
    check("t3_ready", 32'(BYTE_READY), 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    BYTE_VALID = 1'b0;
    repeat (15) step();
    check("t3_err_early", 32'(ERR), 32'd0);
    step();
    check("t3_err",   32'(ERR),        32'd1);
    check("t3_crst0", 32'(CORE_RST_F), 32'd0);
    check("t3_ready0", 32'(BYTE_READY), 32'd0);
    check("t3_nwr",   32'(wr_data.size()), 32'd3);

    // RST mid-load after two bytes
    START = 1'b1; WORD_COUNT = 16'd1;
    step();
    START = 1'b0;
    check("t4_err_clr", 32'(ERR), 32'd0);
    send_byte(8'hA1); send_byte(8'hB2);
    BYTE_VALID = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check_reset_state("t4_async");
    @(negedge CLK);
    RST = 1'b0;
    step();
    check("t4_nwr", 32'(wr_data.size()), 32'd3);

    // WORD_COUNT == 0 from IDLE
    START = 1'b1; WORD_COUNT = 16'd0;
    step();
    START = 1'b0;
    check("t5_done",  32'(DONE),       32'd1);
    check("t5_crst",  32'(CORE_RST_F), 32'd1);
    check("t5_ready", 32'(BYTE_READY), 32'd0);
    step();
    check("t5_hold",  32'(DONE),       32'd1);
    check("t5_nwr",   32'(wr_data.size()), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
